// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch stage with memory request/ready, decode valid/accept and PC update/redirect
module unidade_busca #(
  parameter int LARGURA_END   = 8,
  parameter int LARGURA_INSTR = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [LARGURA_END-1:0]   SaidaPC,
  output logic [LARGURA_END-1:0]   EntradaPC,
  output logic                     EscPC,
  output logic [LARGURA_END-1:0]   MemEnd,
  output logic                     MemLer,
  input  logic                     MemPronto,
  input  logic [LARGURA_INSTR-1:0] MemDado,
  output logic [LARGURA_INSTR-1:0] Instr,
  output logic [LARGURA_END-1:0]   InstrPC,
  output logic                     InstrValida,
  input  logic                     InstrAceita,
  input  logic                     Desvio,
  input  logic [LARGURA_END-1:0]   AlvoDesvio
);
  typedef enum logic [1:0] {INICIO, BUSCA, ENTREGA, ESPERA} estado_t;
  estado_t estado;
  assign MemEnd = SaidaPC;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado      <= INICIO;
      EntradaPC   <= '0;
      EscPC       <= 1'b0;
      MemLer      <= 1'b0;
      Instr       <= '0;
      InstrPC     <= '0;
      InstrValida <= 1'b0;
    end else begin
      EscPC <= 1'b0;
      // redirect outranks memory data and accept; a fetched word in flight is dropped
      if (estado != INICIO && Desvio) begin
        EntradaPC   <= AlvoDesvio;
        EscPC       <= 1'b1;
        InstrValida <= 1'b0;
        MemLer      <= 1'b0;
        estado      <= ESPERA;
      end else begin
        case (estado)
          INICIO: begin
            MemLer <= 1'b1;
            estado <= BUSCA;
          end
          BUSCA: if (MemPronto) begin
            Instr       <= MemDado;
            InstrPC     <= SaidaPC;
            EntradaPC   <= SaidaPC + 1'b1;
            EscPC       <= 1'b1;
            InstrValida <= 1'b1;
            MemLer      <= 1'b0;
            estado      <= ENTREGA;
          end
          ENTREGA: if (InstrAceita) begin
            InstrValida <= 1'b0;
            MemLer      <= 1'b1;
            estado      <= BUSCA;
          end
          default: begin
            MemLer <= 1'b1;
            estado <= BUSCA;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_unidade_busca.sv
// tb_unidade_busca: vector table plus redirect/reset sequences, scoreboard of fetched words
module tb_unidade_busca;
  logic clock = 1'b0, reset = 1'b1;
  logic [7:0] SaidaPC, EntradaPC, MemEnd, InstrPC, AlvoDesvio = 8'h00;
  logic EscPC, MemLer, InstrValida;
  logic MemPronto = 1'b0, InstrAceita = 1'b0, Desvio = 1'b0;
  logic [15:0] MemDado = 16'h0000, Instr;
  logic load_pc = 1'b0;
  logic [7:0] load_val = 8'h00, pc = 8'h00;
  int checks = 0, errors = 0;

  typedef struct {
    logic        set_pc;
    logic [7:0]  pc;
    int          waits;
    logic [15:0] data;
    int          hold;
    logic        desvio;
    logic [7:0]  alvo;
    logic [15:0] e_instr;
    logic [7:0]  e_ipc;
    logic [7:0]  e_next;
  } vec_t;
  typedef struct {
    logic [15:0] instr;
    logic [7:0]  ipc;
    logic [7:0]  next;
  } exp_t;
  vec_t vecs[5];
  exp_t sb[$];

  unidade_busca dut (
    .clock(clock), .reset(reset), .SaidaPC(SaidaPC), .EntradaPC(EntradaPC), .EscPC(EscPC),
    .MemEnd(MemEnd), .MemLer(MemLer), .MemPronto(MemPronto), .MemDado(MemDado),
    .Instr(Instr), .InstrPC(InstrPC), .InstrValida(InstrValida), .InstrAceita(InstrAceita),
    .Desvio(Desvio), .AlvoDesvio(AlvoDesvio)
  );

  always #5 clock = ~clock;
  assign SaidaPC = pc;
  always @(posedge clock) if (load_pc) pc <= load_val; else if (EscPC) pc <= EntradaPC;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_fetch(input vec_t v);
    exp_t e;
    if (v.set_pc) begin
      load_pc = 1'b1; load_val = v.pc;
      step();
      load_pc = 1'b0;
    end
    chk("req_memler", MemLer, 1);
    chk("req_memend", MemEnd, v.e_ipc);
    for (int i = 0; i < v.waits; i++) begin
      step();
      chk("wait_memler", MemLer, 1);
      chk("wait_valid", InstrValida, 0);
    end
    MemPronto = 1'b1; MemDado = v.data;
    sb.push_back('{v.e_instr, v.e_ipc, v.e_next});
    step();
    MemPronto = 1'b0;
    chk("fetch_valid", InstrValida, 1);
    if (InstrValida) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("fetch_instr", Instr, e.instr);
        chk("fetch_ipc", InstrPC, e.ipc);
        chk("fetch_next", EntradaPC, e.next);
      end
    end
    chk("fetch_escpc", EscPC, 1);
    chk("fetch_memler", MemLer, 0);
    for (int i = 0; i < v.hold; i++) begin
      step();
      chk("hold_valid", InstrValida, 1);
      chk("hold_instr", Instr, v.e_instr);
      chk("hold_memler", MemLer, 0);
      chk("hold_escpc", EscPC, 0);
    end
    InstrAceita = 1'b1; Desvio = v.desvio; AlvoDesvio = v.alvo;
    step();
    InstrAceita = 1'b0; Desvio = 1'b0;
    chk("acc_valid", InstrValida, 0);
    if (v.desvio) begin
      chk("accdes_escpc", EscPC, 1);
      chk("accdes_next", EntradaPC, v.alvo);
      chk("accdes_memler", MemLer, 0);
      step();
      chk("accdes_memler2", MemLer, 1);
      chk("accdes_memend", MemEnd, v.alvo);
      chk("accdes_escpc2", EscPC, 0);
    end else begin
      chk("acc_memler", MemLer, 1);
      chk("acc_memend", MemEnd, v.e_next);
      chk("acc_escpc", EscPC, 0);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h0A, 2, 16'h1234, 0, 1'b0, 8'h00, 16'h1234, 8'h0A, 8'h0B};
    vecs[1] = '{1'b0, 8'h0B, 0, 16'hBEEF, 5, 1'b0, 8'h00, 16'hBEEF, 8'h0B, 8'h0C};
    vecs[2] = '{1'b1, 8'hFF, 1, 16'h00FF, 1, 1'b0, 8'h00, 16'h00FF, 8'hFF, 8'h00};
    vecs[3] = '{1'b0, 8'h00, 0, 16'h5A5A, 0, 1'b0, 8'h00, 16'h5A5A, 8'h00, 8'h01};
    vecs[4] = '{1'b1, 8'h40, 0, 16'h7777, 2, 1'b1, 8'h20, 16'h7777, 8'h40, 8'h41};
    step();
    chk("rst_memler", MemLer, 0);
    chk("rst_escpc", EscPC, 0);
    chk("rst_valid", InstrValida, 0);
    chk("rst_entrada", EntradaPC, 0);
    chk("rst_instr", Instr, 0);
    reset = 1'b0;
    chk("inicio_memler", MemLer, 0);
    step();
    chk("busca_memler", MemLer, 1);
    for (int i = 0; i < 5; i++) do_fetch(vecs[i]);
    // redirect and memory ready in the same BUSCA cycle: data must be dropped
    chk("pre_des_memend", MemEnd, 8'h20);
    MemPronto = 1'b1; MemDado = 16'hDEAD; Desvio = 1'b1; AlvoDesvio = 8'h40;
    step();
    MemPronto = 1'b0; Desvio = 1'b0;
    chk("des_valid", InstrValida, 0);
    chk("des_escpc", EscPC, 1);
    chk("des_next", EntradaPC, 8'h40);
    chk("des_memler", MemLer, 0);
    step();
    chk("des_memler2", MemLer, 1);
    chk("des_memend", MemEnd, 8'h40);
    chk("des_escpc2", EscPC, 0);
    chk("des_valid2", InstrValida, 0);
    // back-to-back redirect while in ESPERA: latest target wins
    Desvio = 1'b1; AlvoDesvio = 8'h30;
    step();
    AlvoDesvio = 8'h31;
    chk("b2b_escpc1", EscPC, 1);
    chk("b2b_next1", EntradaPC, 8'h30);
    step();
    Desvio = 1'b0;
    chk("b2b_escpc2", EscPC, 1);
    chk("b2b_next2", EntradaPC, 8'h31);
    chk("b2b_memler", MemLer, 0);
    step();
    chk("b2b_memler2", MemLer, 1);
    chk("b2b_memend", MemEnd, 8'h31);
    chk("b2b_escpc3", EscPC, 0);
    // async reset between edges while in BUSCA, after a word has been latched
    do_fetch('{1'b0, 8'h31, 0, 16'hCAFE, 0, 1'b0, 8'h00, 16'hCAFE, 8'h31, 8'h32});
    #2 reset = 1'b1;
    #1;
    chk("arst_memler", MemLer, 0);
    chk("arst_escpc", EscPC, 0);
    chk("arst_valid", InstrValida, 0);
    chk("arst_instr", Instr, 0);
    chk("arst_ipc", InstrPC, 0);
    step();
    #2 reset = 1'b0;
    #1;
    chk("rel_memler", MemLer, 0);
    step();
    chk("rel_memler2", MemLer, 1);
    chk("rel_memend", MemEnd, pc);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
